// File: rtl/bit_entry_conditioner.sv
// Step-button bit entry: synchronises the data switch and step button, debounces
// the button, and commits one switch bit per clean press with a one-cycle ena strobe.
module bit_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int HIST_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step_n,
  input  logic              sw_data,
  output logic              sig_to_test,
  output logic              ena,
  output logic [HIST_W-1:0] hist,
  output logic [7:0]        bit_count
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   btn_sync, data_sync;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   commit;

  logic                   sig_q, sig_d;
  logic                   ena_q, ena_d;
  logic [HIST_W-1:0]      hist_q, hist_d;
  logic [7:0]             count_q, count_d;

  assign btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn_step_n};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], sw_data};
  assign btn_sync    = btn_sync_q[SYNC_STAGES-1];
  assign data_sync   = data_sync_q[SYNC_STAGES-1];

  // NOTE: every default is assigned first so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!btn_sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          commit  = 1'b1;
        end
      end
      HELD: begin
        if (btn_sync) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!btn_sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter restarts on any state change and only runs inside the wait states.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == PRESS_WAIT || state_q == RELEASE_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    sig_d   = sig_q;
    hist_d  = hist_q;
    count_d = count_q;
    ena_d   = commit;
    if (commit) begin
      sig_d   = data_sync;
      hist_d  = {hist_q[HIST_W-2:0], data_sync};
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q  <= '1;
      data_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sig_q       <= 1'b0;
      ena_q       <= 1'b0;
      hist_q      <= '0;
      count_q     <= '0;
    end else begin
      btn_sync_q  <= btn_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      ena_q       <= ena_d;
      hist_q      <= hist_d;
      count_q     <= count_d;
    end
  end

  assign sig_to_test = sig_q;
  assign ena         = ena_q;
  assign hist        = hist_q;
  assign bit_count   = count_q;

endmodule

// File: tb/tb_bit_entry_conditioner.sv
// Scoreboard bench for bit_entry_conditioner: stimulus queues the expected commit
// (edge number and output values); a negedge monitor checks every ena against it.
module tb_bit_entry_conditioner;

  localparam int D   = 4;
  localparam int S   = 2;
  localparam int H   = 8;
  localparam int LAT = S + 1 + D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_step_n = 1'b1;
  logic         sw_data = 1'b0;
  logic         sig_to_test;
  logic         ena;
  logic [H-1:0] hist;
  logic [7:0]   bit_count;

  typedef struct {
    int         cyc;
    logic       sig;
    logic [7:0] hist;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_hist = '0;
  logic [7:0] m_cnt  = '0;
  int         cyc    = 0;
  int         total  = 0;
  int         passed = 0;

  bit_entry_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .HIST_W         (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step_n (btn_step_n),
    .sw_data    (sw_data),
    .sig_to_test(sig_to_test),
    .ena        (ena),
    .hist       (hist),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic b);
    exp_t e;
    m_hist = {m_hist[6:0], b};
    m_cnt  = m_cnt + 8'd1;
    e.cyc  = c;
    e.sig  = b;
    e.hist = m_hist;
    e.cnt  = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    check("reset_sig", 32'(sig_to_test), 0);
    check("reset_ena", 32'(ena), 0);
    check("reset_hist", 32'(hist), 0);
    check("reset_count", 32'(bit_count), 0);
    rst = 1'b0;
    m_hist = '0;
    m_cnt  = '0;
  endtask

  // Full clean press/hold/release cycle committing bit b.
  task automatic commit_bit(input logic b);
    sw_data = b;
    tick(3);
    btn_step_n = 1'b0;
    push(cyc + LAT, b);
    tick(12);
    btn_step_n = 1'b1;
    tick(9);
  endtask

  always @(negedge clk) begin
    if (ena) begin
      check("ena_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("ena_edge", 32'(cyc), 32'(e.cyc));
        check("sig_to_test", 32'(sig_to_test), 32'(e.sig));
        check("hist", 32'(hist), 32'(e.hist));
        check("bit_count", 32'(bit_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    tick(1);
    do_reset();

    // 1: single clean press with sw_data=1, button held long afterwards.
    sw_data = 1'b1;
    tick(3);
    btn_step_n = 1'b0;
    push(cyc + LAT, 1'b1);
    tick(20);
    check("t1_sig", 32'(sig_to_test), 1);
    check("t1_hist", 32'(hist), 32'h01);
    check("t1_count", 32'(bit_count), 1);
    btn_step_n = 1'b1;
    tick(9);

    // 2: press bounce (3 low, 1 high, then held low).
    sw_data = 1'b0;
    tick(3);
    btn_step_n = 1'b0;
    tick(3);
    btn_step_n = 1'b1;
    tick(1);
    btn_step_n = 1'b0;
    push(cyc + LAT, 1'b0);
    tick(12);
    btn_step_n = 1'b1;
    tick(9);

    // 4: release bounce after a commit gives no second commit.
    sw_data = 1'b1;
    tick(3);
    btn_step_n = 1'b0;
    push(cyc + LAT, 1'b1);
    tick(12);
    btn_step_n = 1'b1;
    tick(2);
    btn_step_n = 1'b0;
    tick(2);
    btn_step_n = 1'b1;
    tick(9);
    commit_bit(1'b0);
    check("t4_count", 32'(bit_count), 4);

    // 3: sequence 0,1,0,0,1 from reset.
    do_reset();
    commit_bit(1'b0);
    commit_bit(1'b1);
    commit_bit(1'b0);
    commit_bit(1'b0);
    commit_bit(1'b1);
    check("t3_hist", 32'(hist), 32'h09);
    check("t3_count", 32'(bit_count), 5);

    // 5: 256 commits wrap the counter; hist keeps only the last 8 bits.
    do_reset();
    for (int i = 0; i < 255; i++) commit_bit(1'($urandom_range(0, 1)));
    check("t5_count_255", 32'(bit_count), 255);
    commit_bit(1'b1);
    check("t5_count_wrap", 32'(bit_count), 0);
    check("t5_hist", 32'(hist), 32'(m_hist));

    // 6: reset on the would-be commit edge, button held through reset.
    commit_bit(1'b1);
    sw_data = 1'b1;
    tick(3);
    btn_step_n = 1'b0;
    tick(LAT - 1);
    rst = 1'b1;
    tick(1);
    check("t6_ena", 32'(ena), 0);
    check("t6_sig", 32'(sig_to_test), 0);
    check("t6_hist", 32'(hist), 0);
    check("t6_count", 32'(bit_count), 0);
    rst = 1'b0;
    m_hist = '0;
    m_cnt  = '0;
    push(cyc + LAT, 1'b1);
    tick(12);
    btn_step_n = 1'b1;
    tick(20);

    check("queue_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
